axi4_lite_mst_arbiter: RTL and testbench

- Shares one AXI4-Lite master port between N_REQ local requesters, each with a simple req/ack command interface.
- Round-robin arbitration; one outstanding transaction at a time, either a write or a read.
- Sits between test-bench/firmware-model command sources and an AXI4-Lite slave (VIP passthrough or DUT), replacing ad-hoc per-task bus driving.

---
 rtl/axi4_lite_mst_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_axi4_lite_mst_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_mst_arbiter.sv
// axi4_lite_mst_arbiter
// Shares one AXI4-Lite master port between N_REQ req/ack command sources.
// Round-robin grant, a single outstanding transaction (write or read) at a time,
// and every output comes straight from a register.
module axi4_lite_mst_arbiter #(
  parameter int           N_REQ  = 4,
  parameter int           ADDR_W = 32,
  parameter int           DATA_W = 32,
  parameter logic [2:0]   AXPROT = 3'b000,
  localparam int          IDX_W  = $clog2(N_REQ),
  localparam int          STRB_W = DATA_W / 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  // requester command interface
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ-1:0]          i_we,
  input  logic [N_REQ*ADDR_W-1:0]   i_addr,
  input  logic [N_REQ*DATA_W-1:0]   i_wdata,
  input  logic [N_REQ*STRB_W-1:0]   i_wstrb,
  output logic [N_REQ-1:0]          o_ack,
  output logic [DATA_W-1:0]         o_rdata,
  output logic [1:0]                o_resp,
  output logic                      o_busy,
  output logic [IDX_W-1:0]          o_gnt_idx,
  // AXI4-Lite write address
  output logic [ADDR_W-1:0]         o_awaddr,
  output logic [2:0]                o_awprot,
  output logic                      o_awvalid,
  input  logic                      i_awready,
  // AXI4-Lite write data
  output logic [DATA_W-1:0]         o_wdata,
  output logic [STRB_W-1:0]         o_wstrb,
  output logic                      o_wvalid,
  input  logic                      i_wready,
  // AXI4-Lite write response
  input  logic [1:0]                i_bresp,
  input  logic                      i_bvalid,
  output logic                      o_bready,
  // AXI4-Lite read address
  output logic [ADDR_W-1:0]         o_araddr,
  output logic [2:0]                o_arprot,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  // AXI4-Lite read data
  input  logic [DATA_W-1:0]         i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rvalid,
  output logic                      o_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD,
    RD_RESP,
    DONE
  } state_t;

  state_t                 state_reg;
  logic [IDX_W-1:0]       last_grant_reg;

  // per-requester views of the packed command buses
  logic [ADDR_W-1:0]      addr_arr  [N_REQ];
  logic [DATA_W-1:0]      wdata_arr [N_REQ];
  logic [STRB_W-1:0]      wstrb_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = i_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = i_wdata[gi*DATA_W +: DATA_W];
      assign wstrb_arr[gi] = i_wstrb[gi*STRB_W +: STRB_W];
    end
  endgenerate

  // protection bits are a fixed attribute of this master
  assign o_awprot = AXPROT;
  assign o_arprot = AXPROT;

  // round-robin pick: first requesting index at or after last_grant+1, wrapping
  logic             sel_valid_next;
  logic [IDX_W-1:0] sel_idx_next;
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    sel_valid_next = 1'b0;
    sel_idx_next   = '0;
    cand           = 0;
    cand_idx       = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand     = (int'(last_grant_reg) + off) % N_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!sel_valid_next && i_req[cand_idx]) begin
        sel_valid_next = 1'b1;
        sel_idx_next   = cand_idx;
      end
    end
  end

  // a channel counts as finished once its valid has already dropped or handshakes now
  logic aw_done_next;
  logic w_done_next;

  assign aw_done_next = !o_awvalid || i_awready;
  assign w_done_next  = !o_wvalid  || i_wready;

  // transaction sequencer; all bus and requester outputs are registered here
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDX_W'(N_REQ - 1);  // requester 0 wins first
      o_ack          <= '0;
      o_rdata        <= '0;
      o_resp         <= '0;
      o_busy         <= 1'b0;
      o_gnt_idx      <= '0;
      o_awaddr       <= '0;
      o_awvalid      <= 1'b0;
      o_wdata        <= '0;
      o_wstrb        <= '0;
      o_wvalid       <= 1'b0;
      o_bready       <= 1'b0;
      o_araddr       <= '0;
      o_arvalid      <= 1'b0;
      o_rready       <= 1'b0;
    end else begin
      o_ack <= '0;
      case (state_reg)
        IDLE: begin
          if (sel_valid_next) begin
            o_gnt_idx      <= sel_idx_next;
            last_grant_reg <= sel_idx_next;
            o_busy         <= 1'b1;
            if (i_we[sel_idx_next]) begin
              o_awaddr  <= addr_arr[sel_idx_next];
              o_wdata   <= wdata_arr[sel_idx_next];
              o_wstrb   <= wstrb_arr[sel_idx_next];
              o_awvalid <= 1'b1;
              o_wvalid  <= 1'b1;
              state_reg <= WR;
            end else begin
              o_araddr  <= addr_arr[sel_idx_next];
              o_arvalid <= 1'b1;
              state_reg <= RD;
            end
          end
        end

        WR: begin
          if (o_awvalid && i_awready) o_awvalid <= 1'b0;
          if (o_wvalid && i_wready)   o_wvalid  <= 1'b0;
          if (aw_done_next && w_done_next) begin
            o_bready  <= 1'b1;
            state_reg <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (i_bvalid) begin
            o_resp    <= i_bresp;
            o_rdata   <= '0;
            o_bready  <= 1'b0;
            o_ack     <= {{(N_REQ-1){1'b0}}, 1'b1} << o_gnt_idx;
            state_reg <= DONE;
          end
        end

        RD: begin
          if (i_arready) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            state_reg <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (i_rvalid) begin
            o_rdata   <= i_rdata;
            o_resp    <= i_rresp;
            o_rready  <= 1'b0;
            o_ack     <= {{(N_REQ-1){1'b0}}, 1'b1} << o_gnt_idx;
            state_reg <= DONE;
          end
        end

        DONE: begin
          o_busy    <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_mst_arbiter.sv
// Directed bench for axi4_lite_mst_arbiter: a configurable-latency slave model
// plus hand-computed expectations for latency, handshakes, grants and responses.
module tb_axi4_lite_mst_arbiter;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic                     i_clk;
  logic                     i_rst_n;
  logic [N_REQ-1:0]         i_req;
  logic [N_REQ-1:0]         i_we;
  logic [N_REQ*ADDR_W-1:0]  i_addr;
  logic [N_REQ*DATA_W-1:0]  i_wdata;
  logic [N_REQ*STRB_W-1:0]  i_wstrb;
  logic [N_REQ-1:0]         o_ack;
  logic [DATA_W-1:0]        o_rdata;
  logic [1:0]               o_resp;
  logic                     o_busy;
  logic [1:0]               o_gnt_idx;
  logic [ADDR_W-1:0]        o_awaddr;
  logic [2:0]               o_awprot;
  logic                     o_awvalid;
  logic                     i_awready;
  logic [DATA_W-1:0]        o_wdata;
  logic [STRB_W-1:0]        o_wstrb;
  logic                     o_wvalid;
  logic                     i_wready;
  logic [1:0]               i_bresp;
  logic                     i_bvalid;
  logic                     o_bready;
  logic [ADDR_W-1:0]        o_araddr;
  logic [2:0]               o_arprot;
  logic                     o_arvalid;
  logic                     i_arready;
  logic [DATA_W-1:0]        i_rdata;
  logic [1:0]               i_rresp;
  logic                     i_rvalid;
  logic                     o_rready;

  axi4_lite_mst_arbiter #(
    .N_REQ (N_REQ),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .AXPROT(3'b000)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (i_req),
    .i_we     (i_we),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
    .i_wstrb  (i_wstrb),
    .o_ack    (o_ack),
    .o_rdata  (o_rdata),
    .o_resp   (o_resp),
    .o_busy   (o_busy),
    .o_gnt_idx(o_gnt_idx),
    .o_awaddr (o_awaddr),
    .o_awprot (o_awprot),
    .o_awvalid(o_awvalid),
    .i_awready(i_awready),
    .o_wdata  (o_wdata),
    .o_wstrb  (o_wstrb),
    .o_wvalid (o_wvalid),
    .i_wready (i_wready),
    .i_bresp  (i_bresp),
    .i_bvalid (i_bvalid),
    .o_bready (o_bready),
    .o_araddr (o_araddr),
    .o_arprot (o_arprot),
    .o_arvalid(o_arvalid),
    .i_arready(i_arready),
    .i_rdata  (i_rdata),
    .i_rresp  (i_rresp),
    .i_rvalid (i_rvalid),
    .o_rready (o_rready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_count = 0;

  // slave behaviour knobs
  int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0] bresp_cfg = 2'b00;
  logic [1:0] rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // count completion pulses and require them one-hot
  always @(negedge i_clk) begin
    if (o_ack != '0) begin
      ack_count <= ack_count + 1;
      check("ack_onehot", 64'($onehot(o_ack)), 64'd1);
    end
  end

  // slave model: each ready/valid rises after its configured number of waiting cycles
  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
    i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_rresp = 2'b00;
    forever begin
      @(negedge i_clk);
      if (o_awvalid) begin i_awready = (aw_cnt >= aw_delay); aw_cnt++; end
      else begin i_awready = 1'b0; aw_cnt = 0; end
      if (o_wvalid) begin i_wready = (w_cnt >= w_delay); w_cnt++; end
      else begin i_wready = 1'b0; w_cnt = 0; end
      if (o_bready) begin i_bvalid = (b_cnt >= b_delay); i_bresp = bresp_cfg; b_cnt++; end
      else begin i_bvalid = 1'b0; b_cnt = 0; end
      if (o_arvalid) begin i_arready = (ar_cnt >= ar_delay); ar_cnt++; end
      else begin i_arready = 1'b0; ar_cnt = 0; end
      if (o_rready) begin
        i_rvalid = (r_cnt >= r_delay); i_rdata = rdata_cfg; i_rresp = rresp_cfg; r_cnt++;
      end else begin
        i_rvalid = 1'b0; r_cnt = 0;
      end
    end
  end

  // present a command on requester idx; the next rising edge samples it
  task automatic start_cmd(input int idx, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    @(negedge i_clk);
    i_we[idx]                 = we;
    i_addr[idx*ADDR_W +: ADDR_W]  = addr;
    i_wdata[idx*DATA_W +: DATA_W] = data;
    i_wstrb[idx*STRB_W +: STRB_W] = strb;
    i_req[idx]                = 1'b1;
  endtask

  // wait (bounded) for the completion pulse, then release the request in the DONE cycle
  task automatic wait_ack(input int idx, input int lat_in, output int lat);
    bit got;
    got = 1'b0;
    lat = lat_in;
    while (!got && lat < 60) begin
      @(negedge i_clk);
      lat++;
      if (o_ack != '0) got = 1'b1;
    end
    check("ack_seen", 64'(got), 64'd1);
    i_req[idx] = 1'b0;
  endtask

  initial begin
    int lat;
    int a0;
    int n;
    int cyc;
    i_rst_n = 1'b0;
    i_req = '0; i_we = '0; i_addr = '0; i_wdata = '0; i_wstrb = '0;

    // reset state
    repeat (3) @(negedge i_clk);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_ack", 64'(o_ack), 64'd0);
    check("rst_valids", 64'({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}), 64'd0);
    check("rst_gnt", 64'(o_gnt_idx), 64'd0);
    check("rst_rdata", 64'(o_rdata), 64'd0);
    check("prot", 64'({o_awprot, o_arprot}), 64'd0);
    i_rst_n = 1'b1;

    // single write, slave always ready
    start_cmd(0, 1'b1, 32'h4, 32'h1234_5678, 4'hF);
    @(negedge i_clk);
    check("t1_valids", 64'({o_awvalid, o_wvalid}), 64'b11);
    check("t1_awaddr", 64'(o_awaddr), 64'h4);
    check("t1_wdata", 64'(o_wdata), 64'h1234_5678);
    check("t1_wstrb", 64'(o_wstrb), 64'hF);
    check("t1_busy", 64'(o_busy), 64'd1);
    @(negedge i_clk);
    check("t1_valids_drop", 64'({o_awvalid, o_wvalid, o_bready}), 64'b001);
    wait_ack(0, 2, lat);
    check("t1_latency", 64'(lat), 64'd3);
    check("t1_ack", 64'(o_ack), 64'b0001);
    check("t1_resp", 64'(o_resp), 64'd0);
    check("t1_rdata", 64'(o_rdata), 64'd0);
    @(negedge i_clk);
    check("t1_idle", 64'({o_busy, o_ack}), 64'd0);
    $display("txn write req0 addr 0x4 latency %0d", lat);

    // write with AW ready delayed 3 cycles, W immediate
    aw_delay = 3;
    start_cmd(0, 1'b1, 32'h8, 32'hCAFE_F00D, 4'h3);
    a0 = ack_count;
    @(negedge i_clk);
    check("t2_valids", 64'({o_awvalid, o_wvalid}), 64'b11);
    @(negedge i_clk);
    check("t2_w_first", 64'({o_awvalid, o_wvalid}), 64'b10);
    wait_ack(0, 2, lat);
    check("t2_latency", 64'(lat), 64'd6);
    repeat (5) @(negedge i_clk);
    check("t2_one_ack", 64'(ack_count - a0), 64'd1);
    aw_delay = 0;
    $display("txn skewed write req0 addr 0x8 latency %0d", lat);

    // read with rvalid delayed 5 cycles
    r_delay = 5;
    rdata_cfg = 32'hABCD_EF01;
    start_cmd(1, 1'b0, 32'h20, 32'h0, 4'h0);
    @(negedge i_clk);
    check("t3_arvalid", 64'(o_arvalid), 64'd1);
    check("t3_araddr", 64'(o_araddr), 64'h20);
    check("t3_gnt", 64'(o_gnt_idx), 64'd1);
    @(negedge i_clk);
    check("t3_ar_drop", 64'({o_arvalid, o_rready}), 64'b01);
    repeat (2) @(negedge i_clk);
    check("t3_rready_held", 64'(o_rready), 64'd1);
    wait_ack(1, 4, lat);
    check("t3_latency", 64'(lat), 64'd8);
    check("t3_ack", 64'(o_ack), 64'b0010);
    check("t3_rdata", 64'(o_rdata), 64'hABCD_EF01);
    check("t3_resp", 64'(o_resp), 64'd0);
    r_delay = 0;
    $display("txn read req1 addr 0x20 rdata 0x%0h latency %0d", o_rdata, lat);

    // error response on a write, then a normal read
    bresp_cfg = 2'b10;
    start_cmd(2, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    wait_ack(2, 0, lat);
    check("t5_resp_err", 64'(o_resp), 64'b10);
    check("t5_ack", 64'(o_ack), 64'b0100);
    check("t5_gnt", 64'(o_gnt_idx), 64'd2);
    $display("txn write req2 addr 0x10 resp %0d", o_resp);
    bresp_cfg = 2'b00;
    rdata_cfg = 32'h5A5A_1234;
    start_cmd(2, 1'b0, 32'h14, 32'h0, 4'h0);
    wait_ack(2, 0, lat);
    check("t5_read_lat", 64'(lat), 64'd3);
    check("t5_read_resp", 64'(o_resp), 64'd0);
    check("t5_read_data", 64'(o_rdata), 64'h5A5A_1234);
    $display("txn read req2 addr 0x14 rdata 0x%0h", o_rdata);

    // round-robin with req0..2 held; last grant was 2 so order is 0,1,2,0,1,2
    @(negedge i_clk);
    i_we[0] = 1'b1; i_addr[0*ADDR_W +: ADDR_W] = 32'h100; i_wdata[0*DATA_W +: DATA_W] = 32'h0; i_wstrb[0*STRB_W +: STRB_W] = 4'hF;
    i_we[1] = 1'b0; i_addr[1*ADDR_W +: ADDR_W] = 32'h104;
    i_we[2] = 1'b1; i_addr[2*ADDR_W +: ADDR_W] = 32'h108; i_wdata[2*DATA_W +: DATA_W] = 32'h2; i_wstrb[2*STRB_W +: STRB_W] = 4'hF;
    i_req = 4'b0111;
    n = 0;
    cyc = 0;
    while (n < 6 && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
      if (o_ack != '0) begin
        check("rr_ack", 64'(o_ack), 64'(1 << (n % 3)));
        check("rr_gnt", 64'(o_gnt_idx), 64'(n % 3));
        $display("txn rr ack %0d from req%0d", n, o_gnt_idx);
        n++;
        if (n == 6) i_req = '0;
      end
    end
    check("rr_count", 64'(n), 64'd6);

    // reset after the AW handshake but before W completes
    w_delay = 5;
    start_cmd(0, 1'b1, 32'h40, 32'h1111_2222, 4'hF);
    @(negedge i_clk);
    check("t6_valids", 64'({o_awvalid, o_wvalid}), 64'b11);
    @(negedge i_clk);
    check("t6_aw_done", 64'({o_awvalid, o_wvalid}), 64'b01);
    a0 = ack_count;
    #2;
    i_rst_n = 1'b0;
    i_req[0] = 1'b0;
    #1;
    check("t6_async_valids", 64'({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}), 64'd0);
    check("t6_async_busy", 64'(o_busy), 64'd0);
    check("t6_async_gnt", 64'(o_gnt_idx), 64'd0);
    repeat (3) @(negedge i_clk);
    check("t6_no_ack", 64'(ack_count - a0), 64'd0);
    i_rst_n = 1'b1;
    w_delay = 0;
    start_cmd(1, 1'b1, 32'h44, 32'h3333_4444, 4'hF);
    wait_ack(1, 0, lat);
    check("t6_latency", 64'(lat), 64'd3);
    check("t6_ack", 64'(o_ack), 64'b0010);
    check("t6_gnt", 64'(o_gnt_idx), 64'd1);
    $display("txn write req1 addr 0x44 after reset latency %0d", lat);

    repeat (2) @(negedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
